ysyx_22051013_if_ctrl: RTL and testbench

Instruction-fetch sequencer for the pipelined core. It owns the architectural fetch PC and issues single-outstanding requests to the instruction memory port. Returned instructions are buffered in a 2-entry queue that feeds the decode stage through a valid/ready handshake. Redirects from ID and EX are applied here: stale in-flight responses are dropped and the queue is flushed.

---
 rtl/ysyx_22051013_if_ctrl.sv | 133 +++++++++++++
 tb/tb_ysyx_22051013_if_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22051013_if_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22051013_if_ctrl
// Description : Instruction-fetch sequencer with a single outstanding request
//               and a 2-entry {pc, inst} queue toward ID.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22051013_if_ctrl #(
  parameter int              PC_W   = 64,
  parameter int              INST_W = 32,
  parameter logic [PC_W-1:0] RST_PC = PC_W'(64'h8000_0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_pc_jump,
  input  logic [PC_W-1:0]   ex_pc_i,
  input  logic              id_pc_jump,
  input  logic [PC_W-1:0]   id_pc_i,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [PC_W-1:0]   if_pc,
  output logic [INST_W-1:0] if_inst,
  input  logic              id_ready
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   r_req_pc;
  logic [PC_W-1:0]   r_q_pc   [2];
  logic [INST_W-1:0] r_q_inst [2];
  logic [1:0]        r_count;
  logic [1:0]        w_count_nxt;
  logic [1:0]        w_wr_slot;
  logic              w_redirect;
  logic [PC_W-1:0]   w_target;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;

  assign w_redirect = ex_pc_jump | id_pc_jump;
  assign w_target   = ex_pc_jump ? ex_pc_i : id_pc_i;

  // Redirect masks the request so a stale address is never granted.
  assign imem_req  = ~rst & (r_state == S_RUN) & (r_count != 2'd2) & ~w_redirect;
  assign imem_addr = r_pc;
  assign w_issue   = imem_req & imem_gnt;

  assign if_valid  = (r_count != 2'd0);
  assign if_pc     = r_q_pc[0];
  assign if_inst   = r_q_inst[0];

  assign w_pop     = if_valid & id_ready;
  assign w_push    = (r_state == S_WAIT) & imem_rvalid & ~w_redirect;
  // Entry 0 is the head; a pop shifts entry 1 down, so the write slot moves too.
  assign w_wr_slot = r_count - {1'b0, w_pop};

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_RUN:   if (w_issue) w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid)     w_state_nxt = S_RUN;
        else if (w_redirect) w_state_nxt = S_DROP;
      end
      S_DROP:  if (imem_rvalid) w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_redirect) begin
      w_count_nxt = 2'd0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + 2'd1;
        2'b01:   w_count_nxt = r_count - 2'd1;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_RUN;
      r_count  <= 2'd0;
      r_pc     <= RST_PC;
      r_req_pc <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_redirect) begin
        r_pc <= w_target;
      end else if (w_issue) begin
        r_pc <= r_pc + PC_W'(4);
      end
      if (w_issue) begin
        r_req_pc <= r_pc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q_pc[0]   <= '0;
      r_q_pc[1]   <= '0;
      r_q_inst[0] <= '0;
      r_q_inst[1] <= '0;
    end else begin
      if (w_pop) begin
        r_q_pc[0]   <= r_q_pc[1];
        r_q_inst[0] <= r_q_inst[1];
      end
      if (w_push) begin
        r_q_pc[w_wr_slot[0]]   <= r_req_pc;
        r_q_inst[w_wr_slot[0]] <= imem_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22051013_if_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_22051013_if_ctrl
// Description : Self-checking bench: table-driven fetch sequence plus directed
//               redirect/backpressure sequences against an instruction scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_22051013_if_ctrl;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  typedef struct {
    logic        rdy;
    logic        exp_req;
    logic [63:0] exp_addr;
    logic        exp_valid;
    logic [63:0] exp_pc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_pc_jump, id_pc_jump;
  logic [63:0] ex_pc_i, id_pc_i;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_valid, id_ready;
  logic [63:0] if_pc;
  logic [31:0] if_inst;

  int          n_chk = 0;
  int          n_err = 0;
  int          mem_wait;
  int          lat;
  logic        gnt_en;
  logic [63:0] mem_addr;
  logic        m_drop;
  logic        cur_gnt;
  logic [63:0] cur_gnt_addr;
  exp_t        sb [$];
  logic [63:0] gnt_log [$];
  logic [63:0] pop_log [$];

  always #5 clk = ~clk;

  ysyx_22051013_if_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .ex_pc_jump  (ex_pc_jump),
    .ex_pc_i     (ex_pc_i),
    .id_pc_jump  (id_pc_jump),
    .id_pc_i     (id_pc_i),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .id_ready    (id_ready)
  );

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF ^ {a[7:0], 24'h0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory response drive, scoreboard pop/compare and push for the current cycle.
  task automatic drive_cycle();
    logic redir;
    exp_t e;
    #1;
    imem_rvalid = (mem_wait == 1);
    imem_rdata  = (mem_wait == 1) ? inst_of(mem_addr) : 32'hDEAD_BEEF;
    imem_gnt    = gnt_en & imem_req;
    #1;
    redir = ex_pc_jump | id_pc_jump;
    if (if_valid && id_ready) begin
      pop_log.push_back(if_pc);
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL pop_unexpected: got pc %h, expected no instruction", if_pc);
      end else begin
        e = sb.pop_front();
        chk("pop_pc", if_pc, e.pc);
        chk("pop_inst", 64'(if_inst), 64'(e.inst));
      end
    end
    if (redir) sb.delete();
    if (imem_rvalid) begin
      if (!m_drop && !redir) begin
        e.pc   = mem_addr;
        e.inst = inst_of(mem_addr);
        sb.push_back(e);
      end
      m_drop = 1'b0;
    end else if (redir && mem_wait > 0) begin
      m_drop = 1'b1;
    end
    cur_gnt      = imem_gnt;
    cur_gnt_addr = imem_addr;
    if (imem_gnt) gnt_log.push_back(imem_addr);
  endtask

  task automatic tick();
    @(posedge clk);
    if (cur_gnt) begin
      mem_wait = lat;
      mem_addr = cur_gnt_addr;
    end else if (mem_wait > 0) begin
      mem_wait--;
    end
    @(negedge clk);
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    ex_pc_jump  = 1'b0;
    id_pc_jump  = 1'b0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      drive_cycle();
      tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    id_ready = 1'b0; gnt_en = 1'b1; lat = 1;
    ex_pc_jump = 1'b0; id_pc_jump = 1'b0; ex_pc_i = '0; id_pc_i = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    mem_wait = 0; mem_addr = '0; m_drop = 1'b0; cur_gnt = 1'b0; cur_gnt_addr = '0;
    sb.delete(); gnt_log.delete(); pop_log.delete();
    #1;
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_valid", 64'(if_valid), 64'd0);
    chk("rst_if_pc", if_pc, 64'd0);
    chk("rst_if_inst", 64'(if_inst), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        seq_tab [7];
    int          n08;
    seq_tab = '{
      '{1'b1, 1'b1, 64'h8000_0000, 1'b0, 64'h0},
      '{1'b1, 1'b0, 64'h0,         1'b0, 64'h0},
      '{1'b1, 1'b1, 64'h8000_0004, 1'b1, 64'h8000_0000},
      '{1'b1, 1'b0, 64'h0,         1'b0, 64'h0},
      '{1'b1, 1'b1, 64'h8000_0008, 1'b1, 64'h8000_0004},
      '{1'b1, 1'b0, 64'h0,         1'b0, 64'h0},
      '{1'b1, 1'b1, 64'h8000_000C, 1'b1, 64'h8000_0008}
    };

    // Sequential fetch with zero-wait memory
    do_reset();
    for (int i = 0; i < 7; i++) begin
      id_ready = seq_tab[i].rdy;
      drive_cycle();
      chk("seq_req", 64'(imem_req), 64'(seq_tab[i].exp_req));
      if (seq_tab[i].exp_req) chk("seq_addr", imem_addr, seq_tab[i].exp_addr);
      chk("seq_valid", 64'(if_valid), 64'(seq_tab[i].exp_valid));
      if (seq_tab[i].exp_valid) chk("seq_if_pc", if_pc, seq_tab[i].exp_pc);
      tick();
    end
    chk("seq_ngrant", 64'(gnt_log.size()), 64'd4);
    if (gnt_log.size() >= 3) begin
      chk("seq_gnt0", gnt_log[0], 64'h8000_0000);
      chk("seq_gnt1", gnt_log[1], 64'h8000_0004);
      chk("seq_gnt2", gnt_log[2], 64'h8000_0008);
    end

    // Backpressure: queue fills, then one pop reopens fetching
    do_reset();
    run(10);
    chk("bp_ngrant", 64'(gnt_log.size()), 64'd2);
    drive_cycle();
    chk("bp_req_full", 64'(imem_req), 64'd0);
    chk("bp_valid", 64'(if_valid), 64'd1);
    chk("bp_head", if_pc, 64'h8000_0000);
    tick();
    id_ready = 1'b1;
    run(1);
    id_ready = 1'b0;
    drive_cycle();
    chk("bp_reissue_req", 64'(imem_req), 64'd1);
    chk("bp_reissue_addr", imem_addr, 64'h8000_0008);
    tick();
    id_ready = 1'b1;
    run(6);
    chk("bp_npops", 64'(pop_log.size() >= 3), 64'd1);
    if (pop_log.size() >= 3) begin
      chk("bp_pop1", pop_log[1], 64'h8000_0004);
      chk("bp_pop2", pop_log[2], 64'h8000_0008);
    end

    // EX redirect while the fetch at 0x..04 is outstanding
    do_reset();
    id_ready = 1'b1;
    run(2);
    lat = 3;
    drive_cycle();
    chk("wr_gnt04", 64'(imem_gnt), 64'd1);
    chk("wr_addr04", imem_addr, 64'h8000_0004);
    tick();
    lat = 1;
    ex_pc_jump = 1'b1; ex_pc_i = 64'h8000_1000;
    drive_cycle();
    chk("wr_req_masked", 64'(imem_req), 64'd0);
    tick();
    for (int c = 0; c < 2; c++) begin
      drive_cycle();
      chk("wr_drop_req", 64'(imem_req), 64'd0);
      chk("wr_drop_valid", 64'(if_valid), 64'd0);
      tick();
    end
    drive_cycle();
    chk("wr_new_req", 64'(imem_req), 64'd1);
    chk("wr_new_addr", imem_addr, 64'h8000_1000);
    chk("wr_new_valid", 64'(if_valid), 64'd0);
    tick();
    run(1);
    drive_cycle();
    chk("wr_tgt_valid", 64'(if_valid), 64'd1);
    chk("wr_tgt_pc", if_pc, 64'h8000_1000);
    tick();

    // Simultaneous EX and ID redirects: EX wins
    do_reset();
    ex_pc_jump = 1'b1; ex_pc_i = 64'h8000_2000;
    id_pc_jump = 1'b1; id_pc_i = 64'h8000_3000;
    drive_cycle();
    chk("sim_req_masked", 64'(imem_req), 64'd0);
    tick();
    drive_cycle();
    chk("sim_req", 64'(imem_req), 64'd1);
    chk("sim_addr", imem_addr, 64'h8000_2000);
    tick();

    // ID redirect in the response cycle
    do_reset();
    id_ready = 1'b1;
    run(1);
    id_pc_jump = 1'b1; id_pc_i = 64'h8000_0100;
    run(1);
    drive_cycle();
    chk("rv_req", 64'(imem_req), 64'd1);
    chk("rv_addr", imem_addr, 64'h8000_0100);
    chk("rv_valid", 64'(if_valid), 64'd0);
    tick();
    run(1);
    drive_cycle();
    chk("rv_tgt_pc", if_pc, 64'h8000_0100);
    tick();

    // Ungranted request retargeted by ID
    do_reset();
    id_ready = 1'b1;
    run(4);
    gnt_en = 1'b0;
    for (int c = 0; c < 2; c++) begin
      drive_cycle();
      chk("ug_hold_req", 64'(imem_req), 64'd1);
      chk("ug_hold_addr", imem_addr, 64'h8000_0008);
      tick();
    end
    id_pc_jump = 1'b1; id_pc_i = 64'h8000_0200;
    drive_cycle();
    chk("ug_req_masked", 64'(imem_req), 64'd0);
    tick();
    gnt_en = 1'b1;
    drive_cycle();
    chk("ug_req", 64'(imem_req), 64'd1);
    chk("ug_addr", imem_addr, 64'h8000_0200);
    tick();
    run(3);
    n08 = 0;
    foreach (gnt_log[j]) if (gnt_log[j] == 64'h8000_0008) n08++;
    chk("ug_no_08_grant", 64'(n08), 64'd0);

    // PC increment wraps modulo 2^64
    do_reset();
    id_ready = 1'b1;
    id_pc_jump = 1'b1; id_pc_i = 64'hFFFF_FFFF_FFFF_FFFC;
    run(1);
    drive_cycle();
    chk("wrap_addr_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    run(1);
    drive_cycle();
    chk("wrap_addr_zero", imem_addr, 64'h0);
    chk("wrap_if_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
